// File: rtl/mem_pkg.sv
// Shared constants and FSM state encoding for the burst master and the
// single-port memory it drives.
package mem_pkg;

  localparam int MEM_DEPTH   = 16;
  localparam int MEM_WIDTH   = 32;
  localparam int MEM_TIMEOUT = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/mem_burst_ctrl.sv
// Burst command master: splits one write/read burst into single-beat
// valid/ready memory accesses, with a ready timeout abort.
module mem_burst_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH      = MEM_DEPTH,
  parameter int WIDTH      = MEM_WIDTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = MEM_TIMEOUT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_wr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_len_i,
  input  logic                  wd_valid_i,
  output logic                  wd_ready_o,
  input  logic [WIDTH-1:0]      wd_data_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  mem_valid_o,
  output logic                  mem_wr_rd_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  input  logic                  mem_ready_i,
  input  logic [WIDTH-1:0]      mem_rdata_i,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e                state_q, state_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] remain_q, remain_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  advance;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      remain_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      timer_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      timer_q  <= timer_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    timer_d  = timer_q;
    done_d   = 1'b0;
    err_d    = err_q;
    advance  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          wr_d     = cmd_wr_i;
          addr_d   = cmd_addr_i;
          remain_d = cmd_len_i;
          err_d    = 1'b0;
          state_d  = cmd_wr_i ? ST_FETCH : ST_ISSUE;
        end
      end
      ST_FETCH: begin
        if (wd_valid_i) begin
          wdata_d = wd_data_i;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_ready_i) begin
          if (wr_q) begin
            advance = 1'b1;
          end else begin
            rdata_d  = mem_rdata_i;
            rvalid_d = 1'b1;
            state_d  = ST_DRAIN;
          end
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (rd_ready_i) begin
          rvalid_d = 1'b0;
          advance  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Beat completion decides end-of-burst in the same cycle, no extra state.
    if (advance) begin
      if (remain_q == '0) begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end else begin
        remain_d = remain_q - 1'b1;
        addr_d   = (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
        state_d  = wr_q ? ST_FETCH : ST_ISSUE;
      end
    end
  end

  assign cmd_ready_o    = (state_q == ST_IDLE);
  assign wd_ready_o     = (state_q == ST_FETCH);
  assign mem_valid_o    = (state_q == ST_ISSUE);
  assign mem_wr_rd_en_o = wr_q;
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;
  assign rd_valid_o     = rvalid_q;
  assign rd_data_o      = rdata_q;
  assign done_o         = done_q;
  assign err_o          = err_q;

endmodule
